// File: rtl/trng_pkg.sv
// Shared types and default limits for the TRNG continuous health-test stage.
package trng_pkg;

  typedef enum logic [1:0] {
    HS_STARTUP = 2'd0,
    HS_RUN     = 2'd1,
    HS_FAIL    = 2'd2
  } health_state_t;

  localparam int TRNG_RCT_CUTOFF      = 32;
  localparam int TRNG_APT_WINDOW      = 512;
  localparam int TRNG_APT_CUTOFF      = 410;
  localparam int TRNG_STARTUP_SAMPLES = 1024;

endpackage

// File: rtl/trng_apt_window.sv
// Adaptive Proportion Test: counts matches against the first sample of each
// window and flags the sample whose match brings the count to the cutoff.
module trng_apt_window
  import trng_pkg::*;
#(
  parameter int APT_WINDOW = TRNG_APT_WINDOW,
  parameter int APT_CUTOFF = TRNG_APT_CUTOFF
) (
  input  logic clk,
  input  logic rstn,
  input  logic sample_en,
  input  logic clear,
  input  logic in_bit,
  output logic apt_fail_now
);

  localparam int IW = $clog2(APT_WINDOW + 1);
  localparam int MW = $clog2(APT_CUTOFF + 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(APT_WINDOW);
  localparam logic [MW-1:0] MATCH_MAX = MW'(APT_CUTOFF);

  logic          ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [MW-1:0] match_q, match_d;

  // idx == 0 marks the first sample after reset/clear; idx == APT_WINDOW marks a closed window.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
    ref_d        = ref_q;
    idx_d        = idx_q;
    match_d      = match_q;
    apt_fail_now = 1'b0;
    if (clear) begin
      ref_d   = 1'b0;
      idx_d   = '0;
      match_d = '0;
    end else if (sample_en) begin
      if (idx_q == '0 || idx_q == IDX_MAX) begin
        ref_d        = in_bit;
        idx_d        = IW'(1);
        match_d      = MW'(1);
        apt_fail_now = (match_d == MATCH_MAX);
      end else begin
        idx_d = idx_q + IW'(1);
        if (in_bit == ref_q && match_q != MATCH_MAX) begin
          match_d      = match_q + MW'(1);
          apt_fail_now = (match_d == MATCH_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rstn) begin
      ref_q   <= 1'b0;
      idx_q   <= '0;
      match_q <= '0;
    end else begin
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      match_q <= match_d;
    end
  end

endmodule

// File: rtl/trng_health_mon.sv
// Continuous RCT/APT health monitor gating raw TRNG samples into the corrector.
// Optional statistics outputs (fail_count, max_run) under TRNG_HEALTH_STATS_EN.
module trng_health_mon
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF      = TRNG_RCT_CUTOFF,
  parameter int APT_WINDOW      = TRNG_APT_WINDOW,
  parameter int APT_CUTOFF      = TRNG_APT_CUTOFF,
  parameter int STARTUP_SAMPLES = TRNG_STARTUP_SAMPLES
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       clear_fail,
  output logic       out_bit,
  output logic       out_valid,
  output logic       healthy,
  output logic       fail_rct,
  output logic       fail_apt
`ifdef TRNG_HEALTH_STATS_EN
  ,
  output logic [7:0] fail_count,
  output logic [7:0] max_run
`endif
);

  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int SW = $clog2(STARTUP_SAMPLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(RCT_CUTOFF);
  localparam logic [SW-1:0] SU_MAX  = SW'(STARTUP_SAMPLES);

  health_state_t state_q, state_d;
  logic          rct_first_q, rct_first_d;
  logic          rct_last_q, rct_last_d;
  logic [RW-1:0] rct_run_q, rct_run_d;
  logic [SW-1:0] su_cnt_q, su_cnt_d;
  logic          out_bit_q, out_bit_d;
  logic          out_valid_q, out_valid_d;
  logic          healthy_q, healthy_d;
  logic          fail_rct_q, fail_rct_d;
  logic          fail_apt_q, fail_apt_d;

  logic sample_en, clear_req, rct_fail_now, apt_fail_now, sample_fail;

  assign sample_en = in_valid && (state_q != HS_FAIL);
  assign clear_req = clear_fail && (state_q == HS_FAIL);

  trng_apt_window #(
    .APT_WINDOW(APT_WINDOW),
    .APT_CUTOFF(APT_CUTOFF)
  ) u_apt (
    .clk         (clk),
    .rstn        (rstn),
    .sample_en   (sample_en),
    .clear       (clear_req),
    .in_bit      (in_bit),
    .apt_fail_now(apt_fail_now)
  );

  always_comb begin
    state_d      = state_q;
    rct_first_d  = rct_first_q;
    rct_last_d   = rct_last_q;
    rct_run_d    = rct_run_q;
    su_cnt_d     = su_cnt_q;
    rct_fail_now = 1'b0;

    if (sample_en) begin
      if (rct_first_q || in_bit != rct_last_q) begin
        rct_last_d = in_bit;
        rct_run_d  = RW'(1);
      end else if (rct_run_q != RUN_MAX) begin
        rct_run_d = rct_run_q + RW'(1);
      end
      rct_first_d  = 1'b0;
      rct_fail_now = (rct_run_d == RUN_MAX);
    end
    sample_fail = rct_fail_now || apt_fail_now;

    fail_rct_d  = fail_rct_q || rct_fail_now;
    fail_apt_d  = fail_apt_q || apt_fail_now;
    out_bit_d   = in_bit;
    out_valid_d = 1'b0;

    case (state_q)
      HS_STARTUP: begin
        if (sample_en) begin
          if (sample_fail) begin
            state_d = HS_FAIL;
          end else begin
            su_cnt_d = su_cnt_q + SW'(1);
            if (su_cnt_d == SU_MAX) state_d = HS_RUN;
          end
        end
      end
      HS_RUN: begin
        out_valid_d = in_valid && !sample_fail;
        if (sample_en && sample_fail) state_d = HS_FAIL;
      end
      HS_FAIL: begin
        // The clear wins over a coincident sample, which sample_en already drops.
        if (clear_fail) begin
          state_d     = HS_STARTUP;
          rct_first_d = 1'b1;
          rct_last_d  = 1'b0;
          rct_run_d   = '0;
          su_cnt_d    = '0;
          fail_rct_d  = 1'b0;
          fail_apt_d  = 1'b0;
        end
      end
      default: state_d = HS_STARTUP;
    endcase

    healthy_d = (state_d == HS_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= HS_STARTUP;
      rct_first_q <= 1'b1;
      rct_last_q  <= 1'b0;
      rct_run_q   <= '0;
      su_cnt_q    <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      healthy_q   <= 1'b0;
      fail_rct_q  <= 1'b0;
      fail_apt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rct_first_q <= rct_first_d;
      rct_last_q  <= rct_last_d;
      rct_run_q   <= rct_run_d;
      su_cnt_q    <= su_cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      healthy_q   <= healthy_d;
      fail_rct_q  <= fail_rct_d;
      fail_apt_q  <= fail_apt_d;
    end
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign healthy   = healthy_q;
  assign fail_rct  = fail_rct_q;
  assign fail_apt  = fail_apt_q;

`ifdef TRNG_HEALTH_STATS_EN
  logic [7:0]  fail_count_q, fail_count_d;
  logic [7:0]  max_run_q, max_run_d;
  logic [31:0] run_ext;
  logic [7:0]  run_sat;

  // Both statistics survive clear_fail; only rstn resets them.
  always_comb begin
    fail_count_d = fail_count_q;
    max_run_d    = max_run_q;
    run_ext      = 32'(rct_run_d);
    run_sat      = (run_ext > 32'd255) ? 8'hFF : run_ext[7:0];
    if (state_q != HS_FAIL && state_d == HS_FAIL && fail_count_q != 8'hFF)
      fail_count_d = fail_count_q + 8'd1;
    if (sample_en && run_sat > max_run_q)
      max_run_d = run_sat;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fail_count_q <= 8'd0;
      max_run_q    <= 8'd0;
    end else begin
      fail_count_q <= fail_count_d;
      max_run_q    <= max_run_d;
    end
  end

  assign fail_count = fail_count_q;
  assign max_run    = max_run_q;
`else
  // Core-only build: no statistics state.
`endif

endmodule

// File: tb/tb_trng_health_mon.sv
// Directed, table-driven bench for trng_health_mon with small test limits.
module tb_trng_health_mon;

  logic clk, rstn, in_bit, in_valid, clear_fail;
  logic out_bit, out_valid, healthy, fail_rct, fail_apt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic  rstn, vld, b, clr;
    logic  ov, h, fr, fa;
    string tag;
  } vec_t;

  vec_t vq[$];

  trng_health_mon #(
    .RCT_CUTOFF     (4),
    .APT_WINDOW     (16),
    .APT_CUTOFF     (12),
    .STARTUP_SAMPLES(8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .clear_fail(clear_fail),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .healthy   (healthy),
    .fail_rct  (fail_rct),
    .fail_apt  (fail_apt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v, input logic b, input logic c,
                              input logic ov, input logic h, input logic fr, input logic fa,
                              input string tag);
    vec_t x;
    x.rstn = r; x.vld = v; x.b = b; x.clr = c;
    x.ov = ov; x.h = h; x.fr = fr; x.fa = fa; x.tag = tag;
    return x;
  endfunction

  function automatic void add(input logic r, input logic v, input logic b, input logic c,
                              input logic ov, input logic h, input logic fr, input logic fa,
                              input string tag);
    vq.push_back(mk(r, v, b, c, ov, h, fr, fa, tag));
  endfunction

  // One valid sample per character of bits, all sharing the same expected flags.
  function automatic void add_bits(input string tag, input string bits,
                                   input logic ov, input logic h, input logic fr, input logic fa);
    for (int i = 0; i < bits.len(); i++)
      add(1'b1, 1'b1, (bits[i] == "1"), 1'b0, ov, h, fr, fa, tag);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare the registered outputs 1 ns after the edge.
  task automatic apply(input vec_t v, input int idx);
    string n;
    rstn       = v.rstn;
    in_valid   = v.vld;
    in_bit     = v.b;
    clear_fail = v.clr;
    @(posedge clk);
    #1;
    n = $sformatf("%s#%0d", v.tag, idx);
    check({n, " out_valid"}, out_valid, v.ov);
    check({n, " out_bit"},   out_bit,   v.rstn & v.b);
    check({n, " healthy"},   healthy,   v.h);
    check({n, " fail_rct"},  fail_rct,  v.fr);
    check({n, " fail_apt"},  fail_apt,  v.fa);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear_fail = 1'b0;

    add(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    add(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    // Startup on alternating bits; the 8th sample enters RUN but is not forwarded.
    add_bits("t1_startup",   "0101010", 0, 0, 0, 0);
    add_bits("t1_done",      "1",       0, 1, 0, 0);
    add_bits("t1_first_fwd", "0",       1, 1, 0, 0);
    // Run of four 1s with an idle cycle inside; idle cycles do not break the run.
    add_bits("t2_run",       "11",      1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, "t2_idle");
    add_bits("t2_run",       "1",       1, 1, 0, 0);
    add_bits("t2_rct_fail",  "1",       0, 0, 1, 0);
    add_bits("fail_ignore",  "1",       0, 0, 1, 0);
    // Clear with a coincident sample: the sample must not count toward startup.
    add(1, 1, 1, 1, 0, 0, 0, 0, "t5_clear");
    add_bits("t5_startup",   "1010101", 0, 0, 0, 0);
    add_bits("t5_done",      "0",       0, 1, 0, 0);
    // Finish the current window, then a new window with ref=1 reaches 12 matches.
    add_bits("t3_fill",      "10101010",       1, 1, 0, 0);
    add_bits("t3_window",    "11101110111011", 1, 1, 0, 0);
    add_bits("t3_apt_fail",  "1",              0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, "clear2");
    // Window ref=0: the 16th sample is both the 4th zero in a row and the 12th match.
    add_bits("t4_startup",   "0010010", 0, 0, 0, 0);
    add_bits("t4_done",      "0",       0, 1, 0, 0);
    add_bits("t4_run",       "1001000", 1, 1, 0, 0);
    add_bits("t4_both_fail", "0",       0, 0, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, "clear3");
    add_bits("t6_startup",   "1010101", 0, 0, 0, 0);
    add_bits("t6_done",      "0",       0, 1, 0, 0);

    foreach (vq[i]) apply(vq[i], i);

    // clear_fail in RUN is ignored; then a run of three 1s is cut by reset.
    apply(mk(1, 1, 1, 1, 1, 1, 0, 0, "t6_clr_in_run"), 0);
    apply(mk(1, 1, 1, 0, 1, 1, 0, 0, "t6_run"), 1);
    apply(mk(1, 1, 1, 0, 1, 1, 0, 0, "t6_run"), 2);
    apply(mk(0, 1, 1, 0, 0, 0, 0, 0, "t6_reset"), 3);
    // After reset the run restarts at 1, so only the 4th identical bit fails.
    for (int k = 0; k < 3; k++)
      apply(mk(1, 1, 1, 0, 0, 0, 0, 0, "t6_after_reset"), k);
    apply(mk(1, 1, 1, 0, 0, 0, 1, 0, "t6_rct_fail"), 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trng_health_mon.md
Name: trng_health_mon

Overview:
- Continuous health-test stage between trng_core (raw entropy source) and vnc (von Neumann corrector).
- Applies a Repetition Count Test (RCT) and an Adaptive Proportion Test (APT), in the style of SP 800-90B, to every raw sample.
- Forwards samples to the corrector only after a startup test passes and while no failure is latched.
- A stuck or biased source therefore never reaches key assembly.

Parameters:
- RCT_CUTOFF, 32: run length of identical consecutive samples that declares an RCT failure (>=2).
- APT_WINDOW, 512: samples per APT window (>=2).
- APT_CUTOFF, 410: count of window-reference matches that declares an APT failure (<=APT_WINDOW).
- STARTUP_SAMPLES, 1024: failure-free samples required in STARTUP before RUN.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_bit  in  1  raw sample from trng_core
- in_valid  in  1  in_bit is a new sample this cycle
- clear_fail  in  1  single-cycle request to leave FAIL and restart startup testing
- out_bit  out  1  forwarded sample to vnc
- out_valid  out  1  out_bit valid this cycle
- healthy  out  1  1 only in RUN
- fail_rct  out  1  latched RCT failure
- fail_apt  out  1  latched APT failure

Behaviour:
- Reset: rstn sampled on clk only; rstn=0 forces all outputs to 0, state STARTUP, all counters 0, and the "first sample" flags set. Reset mid-operation discards all in-flight state.
- States are STARTUP, RUN and FAIL.
  - STARTUP -> RUN once STARTUP_SAMPLES samples are tested with no failure.
  - STARTUP or RUN -> FAIL on any failing sample.
  - FAIL -> STARTUP on clear_fail=1. This clears fail flags and all counters and sets the first-sample flags.
  - clear_fail outside FAIL is ignored.
- Samples are processed only when in_valid=1. In FAIL, samples are ignored and counters are frozen.
- RCT:
  - First sample: last=in_bit, run=1.
  - Subsequent samples: run<=run+1 if in_bit==last; else run<=1 and last<=in_bit.
  - Failure when the updated run equals RCT_CUTOFF. run saturates at RCT_CUTOFF.
- APT:
  - First sample of a window sets ref=in_bit, match=1, idx=1.
  - Subsequent samples: idx++, and match++ if in_bit==ref.
  - Failure when the updated match equals APT_CUTOFF.
  - When idx reaches APT_WINDOW, the window closes. The next sample starts a new window with a new ref.
- Counter widths are $clog2(limit+1). Counters never wrap.
- Simultaneous RCT and APT failure on one sample sets both flags in the same cycle.
- Output latency: exactly 1 cycle, registered.
  - out_bit <= in_bit.
  - out_valid <= in_valid && state==RUN && the sample did not fail.
- The failing sample and all later samples are never forwarded.
- The sample completing STARTUP is not forwarded. Forwarding starts with the next valid sample.
- healthy, fail_rct and fail_apt are registered and update the cycle after the deciding sample.
- clear_fail and in_valid in the same FAIL cycle: the clear takes effect and that sample is ignored.

Optional Feature:
- Macro: TRNG_HEALTH_STATS_EN.
- Defined:
  - Adds output fail_count[7:0]: saturating count of entries into FAIL, reset by rstn only, not by clear_fail.
  - Adds output max_run[7:0]: largest RCT run seen since reset, saturating at 255.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both cases.

Decomposition:
- Package trng_pkg:
  - typedef enum logic [1:0] health_state_t {HS_STARTUP, HS_RUN, HS_FAIL}.
  - Default constants TRNG_RCT_CUTOFF, TRNG_APT_WINDOW, TRNG_APT_CUTOFF, TRNG_STARTUP_SAMPLES.
- One sub-module: trng_apt_window, which holds the ref/idx/match counters and emits apt_fail_now.
- RCT logic and the FSM stay in the top.

Test Plan (bench params: RCT_CUTOFF=4, APT_WINDOW=16, APT_CUTOFF=12, STARTUP_SAMPLES=8):
1. Reset, then alternating 0101... with in_valid=1 -> healthy=1 one cycle after the 8th sample; first out_valid on the 9th sample +1 cycle; no fail flags.
2. In RUN, feed 1,1,1,1 -> fail_rct=1 and healthy=0 the cycle after the 4th 1; out_valid=1 for the first three 1s only, 0 for the 4th.
3. In RUN, feed a 16-sample window with 12 ones (first sample 1) and no run >=4 -> fail_apt=1 after the 12th match; the RCT flag stays 0.
4. Feed 0,0,0,0 with the 4th 0 also making APT match 12 -> fail_rct and fail_apt both set in the same cycle.
5. In FAIL, pulse clear_fail together with in_valid -> state STARTUP, flags cleared, that sample ignored; 8 clean samples later healthy=1.
6. Deassert rstn mid-RUN during a run of 3 -> all outputs 0 next cycle; after release, 3 further identical bits do not fail the RCT (run restarted at 1).
